// File: rtl/ifu_pkg.sv
// Shared fetch-unit types: FSM encoding, reset PC, fetch entry, buffer depth, next-PC select.
// Latency: n/a (declarations and one helper function only).
// Backpressure: n/a.
package ifu_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam int          FIFO_DEPTH   = 2;

    // Fetch sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } fetch_state_e;

    // Next-PC source select, shared with the next-PC logic
    typedef enum logic [1:0] {
        NPC_SEQ    = 2'd0,
        NPC_BRANCH = 2'd1,
        NPC_JUMP   = 2'd2,
        NPC_JR     = 2'd3
    } npc_sel_e;

    // One buffered instruction tagged with its fetch address
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    // Sequential fetch step, wraps modulo 2^32
    function automatic logic [31:0] pc_inc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/ifu_fifo.sv
// Two-entry synchronous FIFO of fetch entries with flush; head is a registered entry.
// Latency: push in cycle N is visible at the head in cycle N+1.
// Backpressure: push is refused when full unless a pop happens in the same cycle.
module ifu_fifo
    import ifu_pkg::*;
(
    input  logic         clk,
    input  logic         rstn,
    input  logic         flush_i,
    input  logic         push_i,
    input  fetch_entry_t push_dat_i,
    input  logic         pop_i,
    output fetch_entry_t head_dat_o,
    output logic [1:0]   count_o,
    output logic         full_o
);

    fetch_entry_t mem_q [FIFO_DEPTH];
    logic         wr_q;
    logic         rd_q;
    logic [1:0]   cnt_q;
    logic [1:0]   cnt_d;
    logic         do_push;
    logic         do_pop;

    assign full_o     = (cnt_q == 2'd2);
    assign do_pop     = pop_i && (cnt_q != 2'd0);
    assign do_push    = push_i && (!full_o || do_pop);
    assign cnt_d      = cnt_q + {1'b0, do_push} - {1'b0, do_pop};
    assign head_dat_o = mem_q[rd_q];
    assign count_o    = cnt_q;

    // Storage, pointers and occupancy; flush empties without touching storage
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_q  <= 1'b0;
            rd_q  <= 1'b0;
            cnt_q <= 2'd0;
        end else if (flush_i) begin
            wr_q  <= 1'b0;
            rd_q  <= 1'b0;
            cnt_q <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= push_dat_i;
                wr_q        <= ~wr_q;
            end
            if (do_pop) begin
                rd_q <= ~rd_q;
            end
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ifu_fetch.sv
// Fetch unit: owns the fetch PC, issues one-outstanding imem requests, buffers {pc,inst} for decode.
// Latency: rvalid in cycle N gives inst_valid_o in N+1; redirect at edge N steers imem_addr_o from N+1.
// Backpressure: no request while buffer+outstanding would exceed 2; IFU_MISALIGN_CHK_EN adds misalign_o.
module ifu_fetch
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
)
(
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] npc_i,
    input  logic        redirect_i,
    output logic [31:0] pc_o,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc_o,
    input  logic        inst_ready_i
`ifdef IFU_MISALIGN_CHK_EN
    ,
    output logic        misalign_o
`endif
);

    fetch_state_e state_q, state_d;
    logic [31:0]  fpc_q, fpc_d;
    logic [31:0]  ipc_q, ipc_d;
    logic         drop_q, drop_d;
    logic         misalign_q, misalign_d;

    logic [31:0]  npc_eff;
    logic         npc_bad;
    logic         req_fire;
    logic         push;
    logic         pop;
    logic         flush;
    fetch_entry_t push_dat;
    fetch_entry_t head;
    logic [1:0]   fifo_cnt;
    logic         fifo_full;

`ifdef IFU_MISALIGN_CHK_EN
    assign npc_eff    = npc_i;
    assign npc_bad    = (npc_i[1:0] != 2'b00);
    assign misalign_o = misalign_q;
`else
    logic unused_npc_lsb;
    assign unused_npc_lsb = ^npc_i[1:0];
    assign npc_eff        = {npc_i[31:2], 2'b00};
    assign npc_bad        = 1'b0;
`endif

    // Nothing is outstanding in REQ, so only the buffer fill limits a new request
    assign imem_req_o   = (state_q == ST_REQ) && !fifo_full;
    assign imem_addr_o  = {fpc_q[31:2], 2'b00};
    assign req_fire     = imem_req_o && imem_gnt_i;
    assign push_dat     = '{pc: ipc_q, inst: imem_rdata_i};

    assign inst_valid_o = (fifo_cnt != 2'd0);
    assign inst_o       = inst_valid_o ? head.inst : 32'd0;
    assign pc_o         = inst_valid_o ? head.pc : fpc_q;
    assign inst_pc_o    = pc_o;

    // Sequencer next state; a redirect overrides everything and cancels push/pop
    always_comb begin
        state_d    = state_q;
        fpc_d      = fpc_q;
        ipc_d      = ipc_q;
        drop_d     = drop_q;
        misalign_d = misalign_q;
        push       = 1'b0;
        pop        = inst_valid_o && inst_ready_i;
        flush      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!misalign_q) state_d = ST_REQ;
            end
            ST_REQ: begin
                if (req_fire) begin
                    ipc_d   = fpc_q;
                    fpc_d   = pc_inc(fpc_q);
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_rvalid_i) begin
                    if (drop_q) drop_d = 1'b0;
                    else        push   = 1'b1;
                    state_d = ST_REQ;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (redirect_i) begin
            fpc_d = npc_eff;
            flush = 1'b1;
            push  = 1'b0;
            pop   = 1'b0;
            if (npc_bad) begin
                // Parked in IDLE, which ignores any late rvalid, so no drop is needed
                misalign_d = 1'b1;
                drop_d     = 1'b0;
                state_d    = ST_IDLE;
            end else begin
                misalign_d = 1'b0;
                // A response arriving this very cycle settles the old request
                if (req_fire || ((state_q == ST_WAIT) && !imem_rvalid_i)) begin
                    drop_d  = 1'b1;
                    state_d = ST_WAIT;
                end else begin
                    drop_d  = 1'b0;
                    state_d = ST_REQ;
                end
            end
        end
    end

    // Sequencer and fetch PC registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            fpc_q      <= RESET_PC;
            ipc_q      <= RESET_PC;
            drop_q     <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            fpc_q      <= fpc_d;
            ipc_q      <= ipc_d;
            drop_q     <= drop_d;
            misalign_q <= misalign_d;
        end
    end

    ifu_fifo u_fifo (
        .clk        (clk),
        .rstn       (rstn),
        .flush_i    (flush),
        .push_i     (push),
        .push_dat_i (push_dat),
        .pop_i      (pop),
        .head_dat_o (head),
        .count_o    (fifo_cnt),
        .full_o     (fifo_full)
    );

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch with a scripted instruction memory and a {pc,inst} scoreboard.
// Memory grants only up to grant_limit, after gnt_delay waiting cycles, rvalid rv_delay cycles late.
// Decode handshake pops are compared in order against expected entries.
module tb_ifu_fetch;
    import ifu_pkg::*;

    logic        clk;
    logic        rstn;
    logic [31:0] npc_i;
    logic        redirect_i;
    logic [31:0] pc_o;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        inst_ready_i;
`ifdef IFU_MISALIGN_CHK_EN
    logic        misalign_o;
`endif

    ifu_fetch dut (
        .clk           (clk),
        .rstn          (rstn),
        .npc_i         (npc_i),
        .redirect_i    (redirect_i),
        .pc_o          (pc_o),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .inst_valid_o  (inst_valid_o),
        .inst_o        (inst_o),
        .inst_pc_o     (inst_pc_o),
        .inst_ready_i  (inst_ready_i)
`ifdef IFU_MISALIGN_CHK_EN
        ,
        .misalign_o    (misalign_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    fetch_entry_t exp_q[$];
    logic [31:0]  exp_addr_q[$];

    int          grant_limit = 0;
    int          gnt_total   = 0;
    int          gnt_delay   = 0;
    int          rv_delay    = 0;
    int          wait_cnt    = 0;
    int          last_wait   = 0;
    int          rv_cnt      = 0;
    logic        rv_pend     = 1'b0;
    logic [31:0] rv_addr     = '0;
    logic        held_vld    = 1'b0;
    logic [31:0] held_addr   = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    function automatic void check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endfunction

    function automatic void expect_fetch(input logic [31:0] a);
        fetch_entry_t e;
        e.pc   = a;
        e.inst = mem_word(a);
        exp_addr_q.push_back(a);
        exp_q.push_back(e);
    endfunction

    // Instruction memory: all drive changes happen on the falling edge
    always @(negedge clk) begin
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        if (rv_pend) begin
            if (rv_cnt == 0) begin
                imem_rvalid_i = 1'b1;
                imem_rdata_i  = mem_word(rv_addr);
                rv_pend       = 1'b0;
            end else begin
                rv_cnt--;
            end
        end
        if (imem_req_o) begin
            if (held_vld) check("addr_stable", imem_addr_o, held_addr);
            if (gnt_total < grant_limit && wait_cnt >= gnt_delay) begin
                imem_gnt_i = 1'b1;
                gnt_total++;
                last_wait  = wait_cnt;
                wait_cnt   = 0;
                held_vld   = 1'b0;
                rv_pend    = 1'b1;
                rv_cnt     = rv_delay;
                rv_addr    = imem_addr_o;
                check("grant_expected", {31'd0, exp_addr_q.size() != 0}, 32'd1);
                if (exp_addr_q.size() != 0) check("grant_addr", imem_addr_o, exp_addr_q.pop_front());
            end else begin
                if (gnt_total < grant_limit) wait_cnt++;
                held_addr = imem_addr_o;
                held_vld  = !redirect_i;
                if (redirect_i) wait_cnt = 0;
            end
        end else begin
            held_vld = 1'b0;
            wait_cnt = 0;
        end
    end

    // Decode side: every accepted head is compared against the scoreboard
    always @(negedge clk) begin
        if (rstn && inst_valid_o && inst_ready_i && !redirect_i) begin
            check("pop_expected", {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) begin
                fetch_entry_t e;
                e = exp_q.pop_front();
                check("inst_pc", inst_pc_o, e.pc);
                check("pc_o", pc_o, e.pc);
                check("inst", inst_o, e.inst);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input int bound);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || exp_addr_q.size() != 0) && n < bound) begin
            tick(1);
            n++;
        end
        check("drain", 32'(exp_q.size() + exp_addr_q.size()), 32'd0);
    endtask

    task automatic wait_grant(input int bound);
        int g0;
        g0 = gnt_total;
        for (int i = 0; i < bound && gnt_total == g0; i++) tick(1);
        check("grant_seen", 32'(gnt_total), 32'(g0 + 1));
    endtask

    task automatic redirect(input logic [31:0] target);
        redirect_i = 1'b1;
        npc_i      = target;
        tick(1);
        redirect_i = 1'b0;
    endtask

    initial begin
        int g0;
        rstn         = 1'b0;
        redirect_i   = 1'b0;
        npc_i        = '0;
        inst_ready_i = 1'b1;
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = '0;
        tick(3);

        // Reset values
        check("rst_req", {31'd0, imem_req_o}, 32'd0);
        check("rst_addr", imem_addr_o, 32'h0);
        check("rst_valid", {31'd0, inst_valid_o}, 32'd0);
        check("rst_inst", inst_o, 32'h0);
        check("rst_pc", pc_o, 32'h0);
        check("rst_inst_pc", inst_pc_o, 32'h0);
`ifdef IFU_MISALIGN_CHK_EN
        check("rst_misalign", {31'd0, misalign_o}, 32'd0);
`endif
        rstn = 1'b1;
        check("idle_req", {31'd0, imem_req_o}, 32'd0);
        tick(1);
        check("first_req", {31'd0, imem_req_o}, 32'd1);
        check("first_addr", imem_addr_o, 32'h0);

        // Sequential fetch, 1-cycle memory
        expect_fetch(32'h0); expect_fetch(32'h4); expect_fetch(32'h8);
        grant_limit = gnt_total + 3;
        wait_drain(60);

        // Decode stalled: buffer fills to two, requests stop
        inst_ready_i = 1'b0;
        g0 = gnt_total;
        exp_addr_q.push_back(32'hC); exp_addr_q.push_back(32'h10);
        exp_addr_q.push_back(32'h14); exp_addr_q.push_back(32'h18);
        grant_limit = gnt_total + 4;
        tick(10);
        check("bp_valid", {31'd0, inst_valid_o}, 32'd1);
        check("bp_req", {31'd0, imem_req_o}, 32'd0);
        check("bp_grants", 32'(gnt_total - g0), 32'd2);
        check("bp_head_pc", inst_pc_o, 32'hC);
        for (int a = 'hC; a <= 'h18; a += 4) begin
            fetch_entry_t e;
            e.pc   = 32'(a);
            e.inst = mem_word(32'(a));
            exp_q.push_back(e);
        end
        inst_ready_i = 1'b1;
        wait_drain(60);

        // Redirect while waiting on 0x1C: its response is dropped
        rv_delay = 3;
        exp_addr_q.push_back(32'h1C);
        grant_limit = gnt_total + 1;
        wait_grant(20);
        redirect(32'h100);
        check("redir_valid", {31'd0, inst_valid_o}, 32'd0);
        check("redir_addr", imem_addr_o, 32'h100);
        check("redir_req_held", {31'd0, imem_req_o}, 32'd0);
        check("redir_pc", pc_o, 32'h100);
        rv_delay = 0;
        expect_fetch(32'h100);
        grant_limit = gnt_total + 1;
        wait_drain(40);

        // Grant delayed by three cycles: address stays put
        gnt_delay = 3;
        expect_fetch(32'h104);
        grant_limit = gnt_total + 1;
        wait_drain(40);
        check("gnt_wait", 32'(last_wait), 32'd3);
        gnt_delay = 0;

        // PC wrap at the top of the address space
        redirect(32'hFFFF_FFF8);
        check("wrap_addr", imem_addr_o, 32'hFFFF_FFF8);
        check("wrap_req", {31'd0, imem_req_o}, 32'd1);
        expect_fetch(32'hFFFF_FFF8); expect_fetch(32'hFFFF_FFFC); expect_fetch(32'h0);
        grant_limit = gnt_total + 3;
        wait_drain(60);

        // Reset with a request outstanding; the late response must be ignored
        rv_delay = 2;
        exp_addr_q.push_back(32'h4);
        grant_limit = gnt_total + 1;
        wait_grant(20);
        rstn = 1'b0;
        #1;
        check("midrst_req", {31'd0, imem_req_o}, 32'd0);
        check("midrst_addr", imem_addr_o, 32'h0);
        check("midrst_pc", pc_o, 32'h0);
        tick(1);
        rstn = 1'b1;
        tick(4);
        check("midrst_novalid", {31'd0, inst_valid_o}, 32'd0);
        check("midrst_req_back", {31'd0, imem_req_o}, 32'd1);
        check("midrst_addr_back", imem_addr_o, 32'h0);
        rv_delay = 0;
        expect_fetch(32'h0);
        grant_limit = gnt_total + 1;
        wait_drain(40);

`ifdef IFU_MISALIGN_CHK_EN
        // Misaligned target parks the unit until an aligned redirect
        redirect(32'h102);
        check("mis_flag", {31'd0, misalign_o}, 32'd1);
        check("mis_req", {31'd0, imem_req_o}, 32'd0);
        tick(3);
        check("mis_parked", {31'd0, imem_req_o}, 32'd0);
        redirect(32'h200);
        check("mis_clear", {31'd0, misalign_o}, 32'd0);
        check("mis_addr", imem_addr_o, 32'h200);
        check("mis_resume", {31'd0, imem_req_o}, 32'd1);
        expect_fetch(32'h200);
`else
        // Target low bits are ignored
        redirect(32'h103);
        check("align_addr", imem_addr_o, 32'h100);
        check("align_req", {31'd0, imem_req_o}, 32'd1);
        expect_fetch(32'h100);
`endif
        grant_limit = gnt_total + 1;
        wait_drain(40);
        tick(4);
        check("end_empty", {31'd0, inst_valid_o}, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
